// File: rtl/linalg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : linalg_pkg
// Description : Shared types and constants for the linear-algebra datapath
//               (fp32 word type, canonical special values, FSM state type).
// Revision    : 1.0 - initial release
// ============================================================================
package linalg_pkg;

  typedef logic [31:0] fp32_t;

  localparam fp32_t FP32_QNAN    = 32'h7FC0_0000;
  localparam fp32_t FP32_POS_INF = 32'h7F80_0000;
  localparam fp32_t FP32_NEG_INF = 32'hFF80_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mat_add_state_e;

endpackage
`default_nettype wire

// File: rtl/fp32_add.sv
`default_nettype none
// ============================================================================
// Module      : fp32_add
// Description : Combinational IEEE-754 single-precision adder.
//               Round-to-nearest-even, subnormal inputs treated as zero,
//               subnormal results flushed to signed zero, canonical qNaN.
// Ports       : a, b  - fp32 operands
//               sum   - fp32 result a + b
// Revision    : 1.0 - initial release
// ============================================================================
module fp32_add
  import linalg_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);

  logic              a_s, b_s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [7:0]        a_e, b_e;
  logic [22:0]       a_m, b_m;
  logic              swap, big_s, sml_s, sticky, rnd, found;
  logic [7:0]        big_e, sml_e, diff;
  logic [23:0]       big_m, sml_m;
  logic [26:0]       big_x, sml_x0, sml_x, norm;
  logic [27:0]       raw;
  logic [4:0]        lz;
  logic [24:0]       mant;
  logic [22:0]       frac;
  logic signed [10:0] e_n;
  logic [31:0]       gen;

  assign a_s    = a[31];
  assign b_s    = b[31];
  assign a_e    = a[30:23];
  assign b_e    = b[30:23];
  assign a_m    = a[22:0];
  assign b_m    = b[22:0];
  assign a_nan  = (a_e == 8'hFF) && (a_m != 23'd0);
  assign b_nan  = (b_e == 8'hFF) && (b_m != 23'd0);
  assign a_inf  = (a_e == 8'hFF) && (a_m == 23'd0);
  assign b_inf  = (b_e == 8'hFF) && (b_m == 23'd0);
  // Exponent zero covers both true zero and subnormals (flushed on input).
  assign a_zero = (a_e == 8'd0);
  assign b_zero = (b_e == 8'd0);

  // General path: both operands normal and finite.
  always_comb begin
    swap   = {b_e, b_m} > {a_e, a_m};
    big_s  = swap ? b_s : a_s;
    sml_s  = swap ? a_s : b_s;
    big_e  = swap ? b_e : a_e;
    sml_e  = swap ? a_e : b_e;
    big_m  = swap ? {1'b1, b_m} : {1'b1, a_m};
    sml_m  = swap ? {1'b1, a_m} : {1'b1, b_m};
    diff   = big_e - sml_e;
    big_x  = {big_m, 3'b000};
    sml_x0 = {sml_m, 3'b000};
    // Alignment keeps guard/round bits and ORs everything shifted out into sticky.
    if (diff > 8'd26) begin
      sticky = 1'b1;
      sml_x  = 27'd1;
    end else begin
      sticky = |(sml_x0 & ((27'd1 << diff) - 27'd1));
      sml_x  = (sml_x0 >> diff) | {26'd0, sticky};
    end

    if (big_s ^ sml_s) raw = {1'b0, big_x} - {1'b0, sml_x};
    else               raw = {1'b0, big_x} + {1'b0, sml_x};

    lz    = 5'd0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && raw[i]) begin
        lz    = 5'(26 - i);
        found = 1'b1;
      end
    end

    if (raw[27]) begin
      norm = {raw[27:2], raw[1] | raw[0]};
      e_n  = $signed({3'b000, big_e}) + 11'sd1;
    end else begin
      norm = raw[26:0] << lz;
      e_n  = $signed({3'b000, big_e}) - $signed({6'd0, lz});
    end

    // Round half to even on the 24-bit significand.
    rnd  = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant = {1'b0, norm[26:3]} + {24'd0, rnd};
    if (mant[24]) begin
      e_n  = e_n + 11'sd1;
      frac = mant[23:1];
    end else begin
      frac = mant[22:0];
    end

    if (raw == 28'd0)        gen = 32'h0000_0000;   // exact cancellation gives +0
    else if (e_n >= 11'sd255) gen = big_s ? FP32_NEG_INF : FP32_POS_INF;
    else if (e_n <= 11'sd0)   gen = {big_s, 31'd0};
    else                      gen = {big_s, e_n[7:0], frac};
  end

  always_comb begin
    if (a_nan || b_nan)        sum = FP32_QNAN;
    else if (a_inf && b_inf)   sum = (a_s == b_s) ? a : FP32_QNAN;
    else if (a_inf)            sum = a;
    else if (b_inf)            sum = b;
    else if (a_zero && b_zero) sum = {a_s & b_s, 31'd0};
    else if (a_zero)           sum = b;
    else if (b_zero)           sum = a;
    else                       sum = gen;
  end

endmodule
`default_nettype wire

// File: rtl/mat_add_seq.sv
`default_nettype none
// ============================================================================
// Module      : mat_add_seq
// Description : Sequential element-wise fp32 matrix adder C = A + B using one
//               shared adder, one element per clock in row-major order.
// Ports       : clk, rst_n        - clock, async active-low reset
//               start             - request, sampled only in IDLE
//               a_mat, b_mat      - operands, row-major packed fp32
//               busy, done        - status (done is a one-cycle pulse)
//               sum_mat           - registered result
// Revision    : 1.0 - initial release
// ============================================================================
module mat_add_seq
  import linalg_pkg::*;
#(
  parameter int M = 2,
  parameter int N = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [M-1:0][N-1:0][31:0] a_mat,
  input  logic [M-1:0][N-1:0][31:0] b_mat,
  output logic                      busy,
  output logic                      done,
  output logic [M-1:0][N-1:0][31:0] sum_mat
);

  localparam int ELEMS  = M * N;
  localparam int IDX_W  = (ELEMS > 1) ? $clog2(ELEMS) : 1;
  localparam int DATA_W = ELEMS * 32;

  mat_add_state_e    state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] a_cap_q, a_cap_d, b_cap_q, b_cap_d, sum_q, sum_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic [31:0]       a_el, b_el, add_res;
  logic              last;

  // Packed [M][N] layout flattens so that element idx = i*N+j sits at bits idx*32.
  assign a_el = a_cap_q[32*int'(idx_q) +: 32];
  assign b_el = b_cap_q[32*int'(idx_q) +: 32];
  assign last = (idx_q == IDX_W'(ELEMS - 1));

  fp32_add u_add (
    .a   (a_el),
    .b   (b_el),
    .sum (add_res)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_cap_d = a_cap_q;
    b_cap_d = b_cap_q;
    sum_d   = sum_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          a_cap_d = a_mat;
          b_cap_d = b_mat;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d[32*int'(idx_q) +: 32] = add_res;
        if (last) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_cap_q <= '0;
      b_cap_q <= '0;
      sum_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_cap_q <= a_cap_d;
      b_cap_q <= b_cap_d;
      sum_q   <= sum_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign sum_mat = sum_q;

endmodule
`default_nettype wire
